// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - state/command enums, command field positions and ALU opcode constants (CPU_SEQ_CNT_EN aware slice)
package cpu_seq_pkg;

    // Command word layout: {type[6:4], sel_a[3:2], sel_b[1:0]}; EXEC reuses [3:0] as the ALU opcode
    localparam int CMD_W        = 7;
    localparam int CMD_TYPE_MSB = 6;
    localparam int CMD_TYPE_LSB = 4;
    localparam int CMD_SELA_MSB = 3;
    localparam int CMD_SELA_LSB = 2;
    localparam int CMD_SELB_MSB = 1;
    localparam int CMD_SELB_LSB = 0;

    // ALU opcode field carried inside an EXEC command
    localparam int ALU_OP_W   = 4;
    localparam int CMD_OP_MSB = 3;
    localparam int CMD_OP_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_LDAB   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_MRD    = 3'd5,
        S_MWB    = 3'd6,
        S_MWR    = 3'd7
    } state_t;

    // Encodings 3'b101..3'b111 are deliberately absent: they are illegal commands
    typedef enum logic [2:0] {
        CMD_NOP      = 3'b000,
        CMD_LOAD_AB  = 3'b001,
        CMD_EXEC     = 3'b010,
        CMD_STORE    = 3'b011,
        CMD_LOAD_MEM = 3'b100
    } cmd_type_t;

    function automatic logic cmd_type_legal(input logic [2:0] t);
        return (t <= CMD_LOAD_MEM);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - command handshake and datapath control bundle of the cpu_sequencer
interface cpu_sequencer_if #(
    parameter int CNT_W    = 16,
    parameter int OPCODE_W = cpu_seq_pkg::ALU_OP_W
);
    logic                          cmd_valid;
    logic [cpu_seq_pkg::CMD_W-1:0] cmd_in;
    logic                          cpu_rdy;
    logic                          datain_reg_en;
    logic                          aluin_reg_en;
    logic [1:0]                    in_select_a;
    logic [1:0]                    in_select_b;
    logic [OPCODE_W-1:0]           opcode;
    logic                          nvalid_data;
    logic                          aluout_reg_en;
    logic                          selmux2;
    logic                          memoryWrite;
    logic                          memoryRead;
    logic                          cmd_err;
    logic [CNT_W-1:0]              cmd_count;

    // Command source side
    modport master (
        output cmd_valid, cmd_in,
        input  cpu_rdy, datain_reg_en, aluin_reg_en, in_select_a, in_select_b, opcode,
               nvalid_data, aluout_reg_en, selmux2, memoryWrite, memoryRead, cmd_err, cmd_count
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_in,
        output cpu_rdy, datain_reg_en, aluin_reg_en, in_select_a, in_select_b, opcode,
               nvalid_data, aluout_reg_en, selmux2, memoryWrite, memoryRead, cmd_err, cmd_count
    );
endinterface

// File: rtl/cpu_cmd_decode.sv
// rtl/cpu_cmd_decode.sv - combinational split of a command word into type, legality, selects and opcode
module cpu_cmd_decode
    import cpu_seq_pkg::*;
#(
    parameter int OPCODE_W = ALU_OP_W
) (
    input  logic [CMD_W-1:0]    i_cmd,
    output logic [2:0]          o_type,
    output logic                o_legal,
    output logic [1:0]          o_sel_a,
    output logic [1:0]          o_sel_b,
    output logic [OPCODE_W-1:0] o_opcode
);

    // Pure field extraction; the opcode overlaps the select fields by design
    always_comb begin
        o_type   = i_cmd[CMD_TYPE_MSB:CMD_TYPE_LSB];
        o_legal  = cmd_type_legal(i_cmd[CMD_TYPE_MSB:CMD_TYPE_LSB]);
        o_sel_a  = i_cmd[CMD_SELA_MSB:CMD_SELA_LSB];
        o_sel_b  = i_cmd[CMD_SELB_MSB:CMD_SELB_LSB];
        o_opcode = OPCODE_W'(i_cmd[CMD_OP_MSB:CMD_OP_LSB]);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control FSM for the 8-bit CPU datapath; CPU_SEQ_CNT_EN enables cmd_count
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int OPCODE_W = ALU_OP_W
) (
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.slave  bus
);

    state_t              r_state;
    logic [CMD_W-1:0]    r_cmd;
    logic                r_valid;
    logic                r_cpu_rdy;
    logic                r_aluin_en;
    logic [1:0]          r_sel_a;
    logic [1:0]          r_sel_b;
    logic [OPCODE_W-1:0] r_opcode;
    logic                r_nvalid;
    logic                r_aluout_en;
    logic                r_selmux2;
    logic                r_mem_wr;
    logic                r_mem_rd;
    logic                r_cmd_err;

    logic                w_accept;
    logic [CMD_W-1:0]    w_cmd_src;
    logic [2:0]          w_type;
    logic                w_legal;
    logic [1:0]          w_sel_a;
    logic [1:0]          w_sel_b;
    logic [OPCODE_W-1:0] w_opcode;

    // cpu_rdy is only ever high in IDLE, so this is the accept strobe for the external command register
    assign w_accept = r_cpu_rdy & bus.cmd_valid;

    // In IDLE decode the incoming word so DECODE-state outputs (cmd_err) can be registered at accept;
    // everywhere else decode the latched command so a changing cmd_in cannot disturb a running sequence
    assign w_cmd_src = (r_state == S_IDLE) ? bus.cmd_in : r_cmd;

    cpu_cmd_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .i_cmd    (w_cmd_src),
        .o_type   (w_type),
        .o_legal  (w_legal),
        .o_sel_a  (w_sel_a),
        .o_sel_b  (w_sel_b),
        .o_opcode (w_opcode)
    );

    // Sequencer FSM: each branch registers the outputs belonging to the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_valid     <= 1'b0;
            r_cpu_rdy   <= 1'b1;
            r_aluin_en  <= 1'b0;
            r_sel_a     <= 2'd0;
            r_sel_b     <= 2'd0;
            r_opcode    <= '0;
            r_nvalid    <= 1'b1;
            r_aluout_en <= 1'b0;
            r_selmux2   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_cpu_rdy   <= 1'b0;
            r_aluin_en  <= 1'b0;
            r_sel_a     <= 2'd0;
            r_sel_b     <= 2'd0;
            r_opcode    <= '0;
            r_nvalid    <= 1'b1;
            r_aluout_en <= 1'b0;
            r_selmux2   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_cmd_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd     <= bus.cmd_in;
                        r_state   <= S_DECODE;
                        r_cmd_err <= ~w_legal;
                    end else begin
                        r_cpu_rdy <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_state   <= S_IDLE;
                        r_cpu_rdy <= 1'b1;
                    end else begin
                        case (w_type)
                            CMD_LOAD_AB: begin
                                r_state    <= S_LDAB;
                                r_aluin_en <= 1'b1;
                                r_sel_a    <= w_sel_a;
                                r_sel_b    <= w_sel_b;
                            end
                            CMD_EXEC: begin
                                r_state  <= S_EXEC;
                                r_opcode <= w_opcode;
                                r_nvalid <= ~r_valid;
                            end
                            CMD_STORE: begin
                                r_state  <= S_MWR;
                                r_mem_wr <= 1'b1;
                            end
                            CMD_LOAD_MEM: begin
                                r_state  <= S_MRD;
                                r_mem_rd <= 1'b1;
                            end
                            default: begin
                                r_state   <= S_IDLE;
                                r_cpu_rdy <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LDAB: begin
                    r_valid   <= 1'b1;
                    r_state   <= S_IDLE;
                    r_cpu_rdy <= 1'b1;
                end
                S_EXEC: begin
                    r_state     <= S_WB;
                    r_opcode    <= w_opcode;
                    r_aluout_en <= 1'b1;
                end
                S_MRD: begin
                    r_state     <= S_MWB;
                    r_mem_rd    <= 1'b1;
                    r_selmux2   <= 1'b1;
                    r_aluout_en <= 1'b1;
                end
                S_WB, S_MWB, S_MWR: begin
                    r_state   <= S_IDLE;
                    r_cpu_rdy <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cpu_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cpu_rdy       = r_cpu_rdy;
    assign bus.datain_reg_en = w_accept;
    assign bus.aluin_reg_en  = r_aluin_en;
    assign bus.in_select_a   = r_sel_a;
    assign bus.in_select_b   = r_sel_b;
    assign bus.opcode        = r_opcode;
    assign bus.nvalid_data   = r_nvalid;
    assign bus.aluout_reg_en = r_aluout_en;
    assign bus.selmux2       = r_selmux2;
    assign bus.memoryWrite   = r_mem_wr;
    assign bus.memoryRead    = r_mem_rd;
    assign bus.cmd_err       = r_cmd_err;

`ifdef CPU_SEQ_CNT_EN
    logic [CNT_W-1:0] r_cmd_count;
    logic             w_cmd_done;

    // A legal command is done on the edge that returns the FSM to IDLE
    always_comb begin
        w_cmd_done = 1'b0;
        case (r_state)
            S_DECODE:                   w_cmd_done = w_legal && (w_type == CMD_NOP);
            S_LDAB, S_WB, S_MWB, S_MWR: w_cmd_done = 1'b1;
            default:                    w_cmd_done = 1'b0;
        endcase
    end

    // Saturating completed-command counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_count <= '0;
        end else if (w_cmd_done && (r_cmd_count != {CNT_W{1'b1}})) begin
            r_cmd_count <= r_cmd_count + 1'b1;
        end
    end

    assign bus.cmd_count = r_cmd_count;
`else
    assign bus.cmd_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

`ifdef CPU_SEQ_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt();
        return CNT_EN ? 32'(n_done) : 32'd0;
    endfunction

    task automatic idle_outputs(input string tag);
        check({tag, ".cpu_rdy"},     32'(bus.cpu_rdy),       32'd1);
        check({tag, ".nvalid"},      32'(bus.nvalid_data),   32'd1);
        check({tag, ".aluin_en"},    32'(bus.aluin_reg_en),  32'd0);
        check({tag, ".aluout_en"},   32'(bus.aluout_reg_en), 32'd0);
        check({tag, ".selmux2"},     32'(bus.selmux2),       32'd0);
        check({tag, ".mem_rd"},      32'(bus.memoryRead),    32'd0);
        check({tag, ".mem_wr"},      32'(bus.memoryWrite),   32'd0);
        check({tag, ".cmd_err"},     32'(bus.cmd_err),       32'd0);
        check({tag, ".opcode"},      32'(bus.opcode),        32'd0);
        check({tag, ".sel_a"},       32'(bus.in_select_a),   32'd0);
        check({tag, ".sel_b"},       32'(bus.in_select_b),   32'd0);
        check({tag, ".cmd_count"},   32'(bus.cmd_count),     exp_cnt());
    endtask

    // Presents cmd in the accept cycle, returns #1 after the edge that enters DECODE
    task automatic issue(input string tag, input logic [6:0] cmd, input bit hold);
        check({tag, ".rdy_before"}, 32'(bus.cpu_rdy), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_in    = cmd;
        #1;
        check({tag, ".datain_en"}, 32'(bus.datain_reg_en), 32'd1);
        step();
        if (!hold) bus.cmd_valid = 1'b0;
        check({tag, ".dec_rdy"},    32'(bus.cpu_rdy),       32'd0);
        check({tag, ".dec_datain"}, 32'(bus.datain_reg_en), 32'd0);
    endtask

    task automatic do_exec(input string tag, input logic exp_nvalid);
        issue(tag, 7'b010_0011, 1'b0);
        check({tag, ".dec_err"}, 32'(bus.cmd_err), 32'd0);
        step();
        check({tag, ".ex_nvalid"},  32'(bus.nvalid_data),   32'(exp_nvalid));
        check({tag, ".ex_opcode"},  32'(bus.opcode),        32'h3);
        check({tag, ".ex_aluout"},  32'(bus.aluout_reg_en), 32'd0);
        check({tag, ".ex_rdy"},     32'(bus.cpu_rdy),       32'd0);
        step();
        check({tag, ".wb_aluout"},  32'(bus.aluout_reg_en), 32'd1);
        check({tag, ".wb_selmux2"}, 32'(bus.selmux2),       32'd0);
        check({tag, ".wb_opcode"},  32'(bus.opcode),        32'h3);
        check({tag, ".wb_nvalid"},  32'(bus.nvalid_data),   32'd1);
        check({tag, ".wb_rdy"},     32'(bus.cpu_rdy),       32'd0);
        step();
        n_done++;
        idle_outputs({tag, ".end"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_in    = 7'd0;
        #12;
        idle_outputs("in_reset");
        reset = 1'b1;
        step();
        idle_outputs("idle");

        do_exec("exec_noload", 1'b1);

        // LOAD_AB with cmd_valid held and cmd_in changed to STORE while busy
        issue("ldab", 7'b001_10_01, 1'b1);
        bus.cmd_in = 7'b011_01_10;
        step();
        check("ldab.aluin_en", 32'(bus.aluin_reg_en),  32'd1);
        check("ldab.sel_a",    32'(bus.in_select_a),   32'd2);
        check("ldab.sel_b",    32'(bus.in_select_b),   32'd1);
        check("ldab.mem_wr",   32'(bus.memoryWrite),   32'd0);
        check("ldab.datain",   32'(bus.datain_reg_en), 32'd0);
        check("ldab.rdy",      32'(bus.cpu_rdy),       32'd0);
        step();
        bus.cmd_valid = 1'b0;
        n_done++;
        idle_outputs("ldab.end");
        step();
        check("held.mem_wr", 32'(bus.memoryWrite), 32'd0);
        check("held.rdy",    32'(bus.cpu_rdy),     32'd1);

        do_exec("exec_loaded", 1'b0);

        issue("lmem", 7'b100_0000, 1'b0);
        step();
        check("mrd.mem_rd",  32'(bus.memoryRead),    32'd1);
        check("mrd.selmux2", 32'(bus.selmux2),       32'd0);
        check("mrd.aluout",  32'(bus.aluout_reg_en), 32'd0);
        step();
        check("mwb.mem_rd",  32'(bus.memoryRead),    32'd1);
        check("mwb.selmux2", 32'(bus.selmux2),       32'd1);
        check("mwb.aluout",  32'(bus.aluout_reg_en), 32'd1);
        check("mwb.rdy",     32'(bus.cpu_rdy),       32'd0);
        step();
        n_done++;
        idle_outputs("lmem.end");

        issue("store", 7'b011_0000, 1'b0);
        step();
        check("mwr.mem_wr", 32'(bus.memoryWrite), 32'd1);
        check("mwr.mem_rd", 32'(bus.memoryRead),  32'd0);
        check("mwr.rdy",    32'(bus.cpu_rdy),     32'd0);
        step();
        n_done++;
        idle_outputs("store.end");

        issue("nop", 7'b000_0000, 1'b0);
        step();
        n_done++;
        idle_outputs("nop.end");

        issue("illegal", 7'b111_0000, 1'b0);
        check("illegal.err", 32'(bus.cmd_err), 32'd1);
        step();
        idle_outputs("illegal.end");
        step();
        check("illegal.err_gone", 32'(bus.cmd_err),   32'd0);
        check("illegal.count",    32'(bus.cmd_count), exp_cnt());

        // Asynchronous reset in the middle of an EXEC
        issue("rst_exec", 7'b010_0011, 1'b0);
        step();
        check("rst_exec.nvalid", 32'(bus.nvalid_data), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        n_done = 0;
        idle_outputs("rst_exec.async");
        reset = 1'b1;
        step();
        idle_outputs("rst_exec.after");

        do_exec("exec_after_rst", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
